// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded control word and operands, holds on freeze,
// inserts an all-zero bubble on flush, and counts issued, bubble and stall cycles.
module id_exe_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             freeze,
   input  logic             flush,
   input  logic             cnt_clr,
   input  logic             id_valid,
   input  logic [3:0]       exeCmd,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic             wbEn,
   input  logic             branch,
   input  logic             sOut,
   input  logic [31:0]      pc,
   input  logic [31:0]      val_rn,
   input  logic [31:0]      val_rm,
   input  logic             imm,
   input  logic [11:0]      shift_operand,
   input  logic [23:0]      signed_imm_24,
   input  logic [3:0]       dest,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             carry_in,
   output logic             exe_valid,
   output logic [3:0]       exe_cmd,
   output logic             exe_mem_read,
   output logic             exe_mem_write,
   output logic             exe_wb_en,
   output logic             exe_branch,
   output logic             exe_s,
   output logic [31:0]      exe_pc,
   output logic [31:0]      exe_val_rn,
   output logic [31:0]      exe_val_rm,
   output logic             exe_imm,
   output logic [11:0]      exe_shift_operand,
   output logic [23:0]      exe_signed_imm_24,
   output logic [3:0]       exe_dest,
   output logic [3:0]       exe_src1,
   output logic [3:0]       exe_src2,
   output logic             exe_carry,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int ENTRY_W = 156;

   logic [ENTRY_W-1:0] w_entry_in;
   logic [ENTRY_W-1:0] r_entry;
   logic               w_load;
   logic               w_issue;
   logic               w_bubble;
   logic               w_stall;
   logic [CNT_W-1:0]   r_issue_cnt;
   logic [CNT_W-1:0]   r_bubble_cnt;
   logic [CNT_W-1:0]   r_stall_cnt;

   // The whole stage entry is one register so flush and freeze act on every field uniformly.
   assign w_entry_in = {id_valid, exeCmd, memRead, memWrite, wbEn, branch, sOut,
                        pc, val_rn, val_rm, imm, shift_operand, signed_imm_24,
                        dest, src1, src2, carry_in};

   assign {exe_valid, exe_cmd, exe_mem_read, exe_mem_write, exe_wb_en, exe_branch, exe_s,
           exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand, exe_signed_imm_24,
           exe_dest, exe_src1, exe_src2, exe_carry} = r_entry;

   assign w_load   = !flush && !freeze;
   assign w_issue  = w_load && id_valid;
   assign w_bubble = flush || (w_load && !id_valid);
   assign w_stall  = !flush && freeze;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry <= '0;
      end else if (flush) begin
         r_entry <= '0;
      end else if (!freeze) begin
         r_entry <= w_entry_in;
      end
   end

   // Exactly one of issue/bubble/stall is set each cycle; counters wrap freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else if (cnt_clr) begin
         r_issue_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_issue)  r_issue_cnt  <= r_issue_cnt + 1'b1;
         if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (w_stall)  r_stall_cnt  <= r_stall_cnt + 1'b1;
      end
   end

   assign issue_cnt  = r_issue_cnt;
   assign bubble_cnt = r_bubble_cnt;
   assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed scenarios plus randomized flush/freeze/clear traffic,
// checked every cycle against a transaction-level model of the stage entry and counters.
module tb_id_exe_reg;

   localparam int CNT_W = 4;
   localparam int EW    = 156;
   localparam int CMOD  = 1 << CNT_W;

   typedef struct packed {
      logic        valid;
      logic [3:0]  cmd;
      logic        mem_read;
      logic        mem_write;
      logic        wb_en;
      logic        branch;
      logic        s;
      logic [31:0] pc;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic        imm;
      logic [11:0] shift_operand;
      logic [23:0] signed_imm_24;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic        carry;
   } entry_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT connections ----------------
   logic   freeze = 1'b0;
   logic   flush = 1'b0;
   logic   cnt_clr = 1'b0;
   entry_t in_e = '0;
   entry_t out_e;
   logic [CNT_W-1:0] issue_cnt, bubble_cnt, stall_cnt;

   logic        exe_valid, exe_mem_read, exe_mem_write, exe_wb_en, exe_branch, exe_s;
   logic        exe_imm, exe_carry;
   logic [3:0]  exe_cmd, exe_dest, exe_src1, exe_src2;
   logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
   logic [11:0] exe_shift_operand;
   logic [23:0] exe_signed_imm_24;

   assign out_e = {exe_valid, exe_cmd, exe_mem_read, exe_mem_write, exe_wb_en, exe_branch, exe_s,
                   exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand, exe_signed_imm_24,
                   exe_dest, exe_src1, exe_src2, exe_carry};

   id_exe_reg #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
      .id_valid(in_e.valid), .exeCmd(in_e.cmd), .memRead(in_e.mem_read),
      .memWrite(in_e.mem_write), .wbEn(in_e.wb_en), .branch(in_e.branch), .sOut(in_e.s),
      .pc(in_e.pc), .val_rn(in_e.val_rn), .val_rm(in_e.val_rm), .imm(in_e.imm),
      .shift_operand(in_e.shift_operand), .signed_imm_24(in_e.signed_imm_24),
      .dest(in_e.dest), .src1(in_e.src1), .src2(in_e.src2), .carry_in(in_e.carry),
      .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_mem_read(exe_mem_read),
      .exe_mem_write(exe_mem_write), .exe_wb_en(exe_wb_en), .exe_branch(exe_branch),
      .exe_s(exe_s), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
      .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
      .exe_signed_imm_24(exe_signed_imm_24), .exe_dest(exe_dest), .exe_src1(exe_src1),
      .exe_src2(exe_src2), .exe_carry(exe_carry),
      .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   // ---------------- scoreboard / reference model ----------------
   int     n_cmp = 0;
   int     n_err = 0;
   entry_t exp_e = '0;
   int     exp_issue = 0;
   int     exp_bubble = 0;
   int     exp_stall = 0;

   task automatic check_val(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_e      = '0;
      exp_issue  = 0;
      exp_bubble = 0;
      exp_stall  = 0;
   endtask

   // What one clock edge does to the stage, stated at the transaction level.
   task automatic model_edge();
      if (flush)       exp_e = '0;
      else if (!freeze) exp_e = in_e;
      if (cnt_clr) begin
         exp_issue = 0; exp_bubble = 0; exp_stall = 0;
      end else if (flush)       exp_bubble = (exp_bubble + 1) % CMOD;
      else if (freeze)          exp_stall  = (exp_stall + 1) % CMOD;
      else if (in_e.valid)      exp_issue  = (exp_issue + 1) % CMOD;
      else                      exp_bubble = (exp_bubble + 1) % CMOD;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".entry"},  EW'(out_e), EW'(exp_e));
      check_val({tag, ".issue"},  EW'(issue_cnt), EW'(exp_issue));
      check_val({tag, ".bubble"}, EW'(bubble_cnt), EW'(exp_bubble));
      check_val({tag, ".stall"},  EW'(stall_cnt), EW'(exp_stall));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic rand_entry();
      logic [159:0] raw;
      raw  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_e = entry_t'(raw[EW-1:0]);
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int base_bubble, base_stall;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset with every input non-zero, asserted between edges.
      in_e = '1; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      tick("preload");
      @(negedge clk);
      async_reset_check("reset_async");

      // Straight load.
      in_e = '0;
      in_e.valid = 1'b1; in_e.cmd = 4'b0010; in_e.wb_en = 1'b1;
      in_e.val_rn = 32'h0000_0005; in_e.dest = 4'd3;
      tick("load");
      check_val("load.cmd",   EW'(exe_cmd),    EW'(4'b0010));
      check_val("load.wb",    EW'(exe_wb_en),  EW'(1'b1));
      check_val("load.rn",    EW'(exe_val_rn), EW'(32'h5));
      check_val("load.dest",  EW'(exe_dest),   EW'(4'd3));
      check_val("load.issue", EW'(issue_cnt),  EW'(1));

      // Freeze holds for three cycles, then the waiting data loads.
      in_e.pc = 32'h10;
      tick("frz_pre");
      base_stall = exp_stall;
      freeze = 1'b1; in_e.pc = 32'h14;
      for (int i = 0; i < 3; i++) begin
         tick("frz_hold");
         check_val("frz.pc", EW'(exe_pc), EW'(32'h10));
      end
      freeze = 1'b0;
      tick("frz_rel");
      check_val("frz.pc_rel", EW'(exe_pc), EW'(32'h14));
      check_val("frz.stall3", EW'(stall_cnt), EW'((base_stall + 3) % CMOD));

      // Flush wins over freeze.
      base_bubble = exp_bubble; base_stall = exp_stall;
      rand_entry(); in_e.valid = 1'b1;
      flush = 1'b1; freeze = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick("flush_frz");
         check_val("flush.zero", EW'(out_e), EW'(0));
      end
      flush = 1'b0; freeze = 1'b0;
      check_val("flush.bub2",  EW'(bubble_cnt), EW'((base_bubble + 2) % CMOD));
      check_val("flush.stall", EW'(stall_cnt),  EW'(base_stall));

      // Hazard bubble: zero control word with id_valid low passes through.
      base_bubble = exp_bubble;
      rand_entry();
      in_e.valid = 1'b0; in_e.cmd = '0; in_e.mem_read = 1'b0; in_e.mem_write = 1'b0;
      in_e.wb_en = 1'b0; in_e.branch = 1'b0; in_e.s = 1'b0;
      tick("hazard");
      check_val("hazard.valid", EW'(exe_valid),  EW'(1'b0));
      check_val("hazard.wb",    EW'(exe_wb_en),  EW'(1'b0));
      check_val("hazard.bub",   EW'(bubble_cnt), EW'((base_bubble + 1) % CMOD));

      // Counter wrap and clear.
      rand_entry(); in_e.valid = 1'b1; cnt_clr = 1'b1;
      tick("clr_start");
      check_val("clr.issue0", EW'(issue_cnt), EW'(0));
      cnt_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rand_entry(); in_e.valid = 1'b1;
         tick("wrap");
      end
      check_val("wrap.issue1", EW'(issue_cnt), EW'(1));
      rand_entry(); in_e.valid = 1'b1; cnt_clr = 1'b1;
      tick("clr_load");
      check_val("clr.issue_z", EW'(issue_cnt), EW'(0));
      cnt_clr = 1'b0;

      // Random traffic with a mid-run asynchronous reset.
      for (int i = 0; i < 400; i++) begin
         rand_entry();
         flush   = ($urandom_range(0, 7) == 0);
         freeze  = ($urandom_range(0, 3) == 0);
         cnt_clr = ($urandom_range(0, 31) == 0);
         tick("rand");
         if (i == 200) begin
            @(negedge clk);
            async_reset_check("reset_mid");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

Pipeline register between the ID stage (control unit, register file, immediate fields) and the EXE stage of the 32-bit ARM core. Each cycle it captures the decoded control word and operands, holds them under a freeze request, and replaces them with a bubble on a branch flush. It also keeps wrap-around performance counters for issued instructions, bubbles and stall cycles.

## Interface

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- freeze  in  1  hold all pipeline fields (memory stall).
- flush  in  1  branch taken in EXE; next captured entry is a bubble.
- cnt_clr  in  1  synchronous clear of all counters.
- id_valid  in  1  ID entry is a real instruction.
- exeCmd  in  4  ALU command from the control unit.
- memRead, memWrite, wbEn, branch, sOut  in  1 each  control bits from the control unit.
- pc  in  32  PC+4 of the ID instruction.
- val_rn, val_rm  in  32 each  register-file read data.
- imm  in  1  immediate-operand flag.
- shift_operand  in  12  shifter operand field.
- signed_imm_24  in  24  branch offset.
- dest, src1, src2  in  4 each  destination and source register numbers, used for forwarding.
- carry_in  in  1  current status-register C flag.
- exe_valid  out  1  registered id_valid.
- exe_cmd  out  4  registered exeCmd.
- exe_mem_read, exe_mem_write, exe_wb_en, exe_branch, exe_s  out  1 each  registered control bits.
- exe_pc, exe_val_rn, exe_val_rm  out  32 each  registered data.
- exe_imm  out  1; exe_shift_operand  out  12; exe_signed_imm_24  out  24.
- exe_dest, exe_src1, exe_src2  out  4 each; exe_carry  out  1.
- issue_cnt, bubble_cnt, stall_cnt  out  CNT_W each  performance counters.

## Operation

- Every output resets to 0 asynchronously while rst_n = 0, including exe_valid and all counters.
- The next-state action on each rising edge is chosen in priority order:
  1. flush = 1: load a bubble. All exe_* fields go to 0, exe_valid goes to 0. Freeze is ignored.
  2. freeze = 1: every exe_* field holds its value.
  3. Otherwise: load every input into its exe_* register. exe_valid takes id_valid.
- A bubble is all-zero. With exe_wb_en = exe_mem_write = exe_branch = exe_s = 0 it has no architectural effect.
- The control unit already zeroes its control word on a hazard. This block does not re-gate a zero control word; it passes it through with id_valid.
- Counters update on the same edge as the pipeline fields:
  - cnt_clr = 1: all three counters go to 0. This overrides any increment in that cycle.
  - issue_cnt increments on a load (case 3) with id_valid = 1.
  - bubble_cnt increments on a flush (case 1), or on a load with id_valid = 0.
  - stall_cnt increments on a freeze-hold (case 2).
  - Exactly one counter increments per non-reset cycle.
  - All counters wrap modulo 2^CNT_W, with no saturation.
- Reset asserted mid-operation clears everything immediately. Operation resumes on the first rising edge after rst_n rises.

## Timing

- Latency is 1 cycle: inputs sampled on edge N appear on exe_* outputs after edge N.
- No combinational path from any input to any output. All outputs come directly from flops.
- freeze and flush are sampled on the same edge as the data they qualify.
- Consecutive freeze cycles hold indefinitely. Data present on the first non-frozen edge is loaded; the upstream stage keeps that data stable while frozen.
- With flush held for k cycles, k consecutive bubbles load and bubble_cnt rises by k, even if freeze is also high.

## Test plan

- Reset: drive all inputs non-zero, pulse rst_n low between edges. Required: every output reads 0 immediately, without waiting for a clock edge.
- Straight load: exeCmd=4'b0010, wbEn=1, val_rn=32'h0000_0005, dest=4'd3, id_valid=1. Required: values appear one cycle later and issue_cnt=1.
- Freeze: load an entry with pc=32'h10, then freeze for 3 cycles while inputs change to pc=32'h14. Required: exe_pc stays 32'h10 for 3 cycles and becomes 32'h14 on the first unfrozen edge; stall_cnt=3.
- Flush vs freeze: assert flush and freeze together for 2 cycles. Required: all exe_* fields are 0 on both cycles, bubble_cnt=2, stall_cnt unchanged.
- Hazard bubble: id_valid=0 with an all-zero control word. Required: exe_valid=0, exe_wb_en=0, bubble_cnt increments by 1.
- Counter wrap and clear, using CNT_W=4: run 17 valid loads. Required: issue_cnt=1. Then assert cnt_clr together with a valid load. Required: issue_cnt=0 on the next cycle.
